// File: rtl/mul_div_controller_pkg.sv
// mul_div_controller_pkg: shared FSM state encoding and M-extension funct3 codes
package mul_div_controller_pkg;
  typedef enum logic [1:0] {MDC_IDLE = 2'd0, MDC_EXEC = 2'd1, MDC_DONE = 2'd2} mdc_state_t;
  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;
endpackage

// File: rtl/mul_div_controller_if.sv
// mul_div_controller_if: controller <-> mul_div_unit handshake
// master (controller): drives dp_start, dp_op, dp_abort; samples dp_done, dp_result
// slave (datapath): the reverse
interface mul_div_controller_if #(parameter int XLEN = 32);
  logic            dp_start;
  logic [2:0]      dp_op;
  logic            dp_abort;
  logic            dp_done;
  logic [XLEN-1:0] dp_result;
  modport master(output dp_start, dp_op, dp_abort, input dp_done, dp_result);
  modport slave(input dp_start, dp_op, dp_abort, output dp_done, dp_result);
endinterface

// File: rtl/mul_div_controller_watchdog.sv
// mdc_watchdog: EXEC cycle counter, flags the last allowed cycle
// clk/reset: clock, async active-high reset; clr: zero counter; en: count; expired: counter at TIMEOUT-1 while enabled
module mdc_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = en && cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mul_div_controller.sv
// mul_div_controller: sequences the multi-cycle M-extension datapath and stalls the pipeline
// clk/reset: clock, async active-high reset
// ex_*: instruction in EX; flush: kill in-flight op
// dp: datapath handshake (start/op/abort out, done/result in)
// busy/hold_idex/hold_exmem: pipeline stall; result_valid/result/result_rd: captured result; timeout_err: watchdog pulse
module mul_div_controller
  import mul_div_controller_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic                 ex_is_mul_div,
  input  logic [2:0]           ex_funct3,
  input  logic [4:0]           ex_rd,
  input  logic                 flush,
  mul_div_controller_if.master dp,
  output logic                 busy,
  output logic                 hold_idex,
  output logic                 hold_exmem,
  output logic                 result_valid,
  output logic [XLEN-1:0]      result,
  output logic [4:0]           result_rd,
  output logic                 timeout_err
);
  mdc_state_t state, next;
  logic start, cap, expired;
  // reset gates start so every output is 0 while reset is held
  assign start = !reset && state == MDC_IDLE && ex_valid && ex_is_mul_div && !flush;
  assign dp.dp_start = start;
  assign hold_idex = busy;
  assign hold_exmem = busy;
  mdc_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (
    .clk(clk), .reset(reset), .clr(start), .en(state == MDC_EXEC), .expired(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= MDC_IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dp.dp_op <= '0;
      result_rd <= '0;
      result <= '0;
    end else begin
      if (start) begin
        dp.dp_op <= ex_funct3;
        result_rd <= ex_rd;
      end
      if (cap) result <= dp.dp_result;
    end
  always_comb begin
    next = state;
    busy = 1'b0;
    cap = 1'b0;
    dp.dp_abort = 1'b0;
    timeout_err = 1'b0;
    result_valid = 1'b0;
    case (state)
      MDC_IDLE: begin
        busy = start;
        next = start ? MDC_EXEC : MDC_IDLE;
      end
      MDC_EXEC: begin
        busy = 1'b1;
        if (flush) begin
          dp.dp_abort = 1'b1;
          next = MDC_IDLE;
        end else if (dp.dp_done) begin
          cap = 1'b1;
          next = MDC_DONE;
        end else if (expired) begin
          dp.dp_abort = 1'b1;
          timeout_err = 1'b1;
          next = MDC_IDLE;
        end
      end
      MDC_DONE: begin
        result_valid = !flush;
        next = MDC_IDLE;
      end
      default: next = MDC_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mul_div_controller.sv
// tb_mul_div_controller: table, hand-written and random op sequences checked against a transaction model
module tb_mul_div_controller;
  import mul_div_controller_pkg::*;
  localparam int T = 8;
  localparam int AB = 0, DN = 1, TO = 2;
  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          lat;
    int          fl;
    logic [31:0] val;
    int          e;
    int          kind;
  } vec_t;
  logic clk = 0, reset = 1, ex_valid = 0, ex_is_mul_div = 0, flush = 0;
  logic [2:0] ex_funct3 = 0;
  logic [4:0] ex_rd = 0;
  logic busy, hold_idex, hold_exmem, result_valid, timeout_err;
  logic [31:0] result;
  logic [4:0] result_rd;
  logic [31:0] model_res = 0;
  int tests = 0, fails = 0;
  vec_t vecs[11];
  mul_div_controller_if #(.XLEN(32)) dp();
  mul_div_controller #(.XLEN(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_mul_div(ex_is_mul_div),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .flush(flush), .dp(dp),
    .busy(busy), .hold_idex(hold_idex), .hold_exmem(hold_exmem),
    .result_valid(result_valid), .result(result), .result_rd(result_rd),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] outs();
    return {dp.dp_start, dp.dp_abort, busy, hold_idex, hold_exmem, result_valid, timeout_err};
  endfunction
  // transaction outcome: flush beats done beats watchdog; lat/fl are EXEC cycle numbers (0 = never)
  function automatic void predict(input int lat, input int fl, output int e, output int kind);
    int d = lat > 0 ? lat : 1000;
    int m = d < T ? d : T;
    if (fl > 0 && fl <= m) begin e = fl; kind = AB; end
    else if (d <= T) begin e = d; kind = DN; end
    else begin e = T; kind = TO; end
  endfunction
  // cycle k=0 issues the op, k=1..e are EXEC, k=e+1 is DONE (or IDLE after abort)
  task automatic run_op(input vec_t v);
    for (int k = 0; k <= v.e + 1; k++) begin
      @(negedge clk);
      ex_valid = k <= v.e;
      ex_is_mul_div = 1;
      ex_funct3 = k == 0 ? v.f3 : 3'($urandom);
      ex_rd = k == 0 ? v.rd : 5'($urandom);
      flush = v.fl > 0 && k == v.fl;
      dp.dp_done = (v.lat > 0 && k == v.lat) || k == v.e + 1;
      dp.dp_result = (v.lat > 0 && k == v.lat) ? v.val : $urandom;
      #1;
      chk("outs", 32'(outs()), 32'({k == 0, v.kind != DN && k == v.e, k <= v.e, k <= v.e, k <= v.e,
                                    v.kind == DN && k == v.e + 1 && v.fl != k, v.kind == TO && k == v.e}));
      chk("result", result, (v.kind == DN && k > v.e) ? v.val : model_res);
      if (k > 0) begin
        chk("dp_op", 32'(dp.dp_op), 32'(v.f3));
        chk("result_rd", 32'(result_rd), 32'(v.rd));
      end
    end
    if (v.kind == DN) model_res = v.val;
    #1;
    flush = 0;
    dp.dp_done = 0;
    ex_valid = 0;
  endtask
  initial begin
    vec_t r;
    dp.dp_done = 0;
    dp.dp_result = 0;
    vecs = '{
      '{MUL,    5'd5,  3, 0, 32'h0000_0C00, 3, DN},
      '{DIVU,   5'd9,  5, 2, 32'h0000_1234, 2, AB},
      '{DIV,    5'd7,  3, 3, 32'hDEAD_BEEF, 3, AB},
      '{MULH,   5'd2,  0, 0, 32'h0,         8, TO},
      '{MULHU,  5'd6,  8, 0, 32'hAAAA_5555, 8, DN},
      '{DIVU,   5'd1,  9, 0, 32'h1111_2222, 8, TO},
      '{REM,    5'd3,  2, 0, 32'h0000_0111, 2, DN},
      '{REM,    5'd4,  2, 0, 32'h0000_0222, 2, DN},
      '{REMU,   5'd31, 1, 0, 32'hCAFE_F00D, 1, DN},
      '{MULHSU, 5'd8,  4, 5, 32'h0BAD_C0DE, 4, DN},
      '{DIV,    5'd10, 0, 8, 32'h0,         8, AB}
    };
    @(negedge clk);
    ex_valid = 1;
    ex_is_mul_div = 1;
    #1;
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_result", result, 0);
    chk("reset_rd", 32'(result_rd), 0);
    chk("reset_op", 32'(dp.dp_op), 0);
    reset = 0;
    ex_valid = 0;
    foreach (vecs[i]) run_op(vecs[i]);
    @(negedge clk);
    ex_valid = 1;
    ex_funct3 = MUL;
    ex_rd = 5'd12;
    #1;
    chk("mid_start", 32'(dp.dp_start), 1);
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("mid_reset_outs", 32'(outs()), 0);
    chk("mid_reset_result", result, 0);
    chk("mid_reset_rd", 32'(result_rd), 0);
    chk("mid_reset_op", 32'(dp.dp_op), 0);
    @(negedge clk);
    reset = 0;
    ex_valid = 0;
    model_res = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dp.dp_done = k == 1;
      dp.dp_result = 32'h5A5A_5A5A;
      #1;
      chk("post_reset_outs", 32'(outs()), 0);
      chk("post_reset_result", result, 0);
    end
    dp.dp_done = 0;
    for (int n = 0; n < 40; n++) begin
      r.f3 = 3'($urandom);
      r.rd = 5'($urandom);
      r.lat = $urandom_range(0, 10);
      r.fl = $urandom_range(0, 3) == 0 ? $urandom_range(1, 10) : 0;
      r.val = $urandom;
      predict(r.lat, r.fl, r.e, r.kind);
      run_op(r);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
